div_unit: RTL

- Iterative radix-2 integer divider executing RV32M DIV, DIVU, REM and REMU.
- Sits directly downstream of the decoder: it consumes the decoded alu_op together with the rs1/rs2 operand values.
- Multiply and base ALU ops remain in the single-cycle ALU.
- The pipeline stalls on busy and takes the result on the done pulse for writeback to rd.

---
 rtl/div_unit_pkg.sv | 29 ++
 rtl/div_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: decoded ALU op codes,
// divider state encoding and small op-classification helpers.
package div_unit_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_DIV  = 5'd12;
  localparam logic [4:0] ALU_DIVU = 5'd13;
  localparam logic [4:0] ALU_REM  = 5'd14;
  localparam logic [4:0] ALU_REMU = 5'd15;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish in one cycle; otherwise XLEN+2.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [4:0]       op_q, op_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [4:0]       rd_tag_q, rd_tag_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [4:0]       rd_out_q, rd_out_d;
  logic             done_q, done_d;

  // One restoring step: shift {rem,quo} left, trial-subtract with a spare
  // borrow bit because the shifted remainder can need XLEN+1 bits.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] dvs);
    logic [XLEN:0]   trial;
    logic [XLEN+1:0] diff;
    trial = {rem, quo[XLEN-1]};
    diff  = {1'b0, trial} - {2'b00, dvs};
    if (!diff[XLEN+1]) return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
    return {trial[XLEN-1:0], quo[XLEN-2:0], 1'b0};
  endfunction

  logic            in_signed, in_s1, in_s2, in_div0, in_ovf, accept;
  logic [XLEN-1:0] in_mag1, in_mag2, quo_fix, rem_fix;
  logic [2*XLEN-1:0] step_res;

  assign in_signed = is_signed_op(alu_op);
  assign in_s1     = in_signed & rs1_val[XLEN-1];
  assign in_s2     = in_signed & rs2_val[XLEN-1];
  assign in_mag1   = in_s1 ? -rs1_val : rs1_val;
  assign in_mag2   = in_s2 ? -rs2_val : rs2_val;
  assign in_div0   = (rs2_val == '0);
  assign in_ovf    = in_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_val);
  assign accept    = start && (state_q == DIV_IDLE) && is_div_op(alu_op) && !flush;
  assign step_res  = div_step(rem_q, quo_q, dvs_q);
  assign quo_fix   = ((op_q == ALU_DIV) && (s1_q ^ s2_q)) ? -quo_q : quo_q;
  assign rem_fix   = ((op_q == ALU_REM) && s1_q) ? -rem_q : rem_q;

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    op_d     = op_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    rd_tag_d = rd_tag_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;

    unique case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          op_d     = alu_op;
          rd_tag_d = rd_in;
          s1_d     = in_s1;
          s2_d     = in_s2;
          if (in_div0) begin
            done_d   = 1'b1;
            result_d = is_rem_op(alu_op) ? rs1_val : '1;
            rd_out_d = rd_in;
          end else if (in_ovf) begin
            done_d   = 1'b1;
            result_d = is_rem_op(alu_op) ? '0 : rs1_val;
            rd_out_d = rd_in;
          end else begin
            state_d = DIV_CALC;
            cnt_d   = CNT_W'(XLEN - 1);
            rem_d   = '0;
            quo_d   = in_mag1;
            dvs_d   = in_mag2;
          end
        end
      end
      DIV_CALC: begin
        {rem_d, quo_d} = step_res;
        if (cnt_q == '0) state_d = DIV_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DIV_FIX: begin
        state_d  = DIV_IDLE;
        done_d   = 1'b1;
        result_d = is_rem_op(op_q) ? rem_fix : quo_fix;
        rd_out_d = rd_tag_q;
      end
      default: state_d = DIV_IDLE;
    endcase

    // An abort drops the in-flight op; a done already on the outputs stands.
    if (flush) begin
      state_d  = DIV_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      op_q     <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      rd_tag_q <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      op_q     <= op_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      rd_tag_q <= rd_tag_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != DIV_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
